// File: rtl/ram_arbiter.sv
// ram_arbiter: shares one multi-port ram among REQ requesters.
// Each cycle a round-robin scan picks up to PORT pending requests and maps
// them onto ram ports 0..PORT-1 in scan order. Read data is returned to the
// originating requester LAT = 1 + OUTREG cycles after the grant.
// Optional build macro RAM_ARBITER_WCONFLICT_EN: a write whose address matches
// an earlier write selected in the same cycle is held back and stays pending.

`ifndef READ
`define READ 1'b1
`endif
`ifndef WRITE
`define WRITE 1'b0
`endif
`ifndef DISABLE
`define DISABLE 0
`endif
`ifndef ENABLE
`define ENABLE 1
`endif

module ram_arbiter #(
  parameter int DATA   = 32,
  parameter int DEPTH  = 4,
  parameter int PORT   = 2,
  parameter int REQ    = 4,
  parameter int OUTREG = `DISABLE,
  parameter int ADDR   = $clog2(DEPTH)
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic [REQ-1:0]             req,
  input  logic [REQ-1:0]             req_rw_,
  input  logic [REQ-1:0][ADDR-1:0]   req_addr,
  input  logic [REQ-1:0][DATA-1:0]   req_wdata,
  output logic [REQ-1:0]             gnt,
  output logic [REQ-1:0]             rvalid,
  output logic [REQ-1:0][DATA-1:0]   rdata,
  output logic [PORT-1:0]            en,
  output logic [PORT-1:0]            rw_,
  output logic [PORT-1:0][ADDR-1:0]  addr,
  output logic [PORT-1:0][DATA-1:0]  wdata,
  input  logic [PORT-1:0][DATA-1:0]  ram_rdata
);

  localparam int LAT = 1 + OUTREG;
  localparam int IDW = $clog2(REQ);

  // round-robin pointer: first requester examined by the scan
  logic [IDW-1:0] ptr;
  logic [IDW-1:0] ptr_nxt;
  logic           any_gnt;

  // requester id mapped onto each ram port this cycle
  logic [IDW-1:0] slot_id [PORT];

  // per-port read return pipeline: valid bit and requester tag per stage
  logic [LAT-1:0] pipe_v  [PORT];
  logic [IDW-1:0] pipe_id [PORT][LAT];

  // last delivered read data per requester
  logic [REQ-1:0][DATA-1:0] rdata_q;

  // Round-robin selection of up to PORT requests and ram port mapping.
  // Slots are indexed by comparing against a constant port number so that
  // no variable-width port index is needed (keeps PORT=1 legal).
  always_comb begin
    logic [IDW:0]   sum;
    logic [IDW-1:0] idx;
    logic [IDW-1:0] last;
    logic           ok;
    int unsigned    used;

    gnt     = '0;
    en      = '0;
    rw_     = {PORT{`READ}};
    addr    = '0;
    wdata   = '0;
    any_gnt = 1'b0;
    for (int unsigned p = 0; p < PORT; p++) slot_id[p] = '0;
    sum  = '0;
    idx  = '0;
    last = ptr;
    ok   = 1'b0;
    used = 0;

    for (int unsigned k = 0; k < REQ; k++) begin
      sum = {1'b0, ptr} + (IDW+1)'(k);
      if (sum >= (IDW+1)'(REQ)) sum = sum - (IDW+1)'(REQ);
      idx = sum[IDW-1:0];

      if (reset && req[idx] && used < PORT) begin
        ok = 1'b1;
`ifdef RAM_ARBITER_WCONFLICT_EN
        // a write colliding with an earlier selected write keeps its slot
        // empty and waits for a later cycle
        if (req_rw_[idx] == `WRITE) begin
          for (int unsigned p = 0; p < PORT; p++) begin
            if (p < used && en[p] && rw_[p] == `WRITE && addr[p] == req_addr[idx])
              ok = 1'b0;
          end
        end
`endif
        if (ok) begin
          gnt[idx] = 1'b1;
          for (int unsigned p = 0; p < PORT; p++) begin
            if (p == used) begin
              en[p]      = 1'b1;
              rw_[p]     = req_rw_[idx];
              addr[p]    = req_addr[idx];
              wdata[p]   = req_wdata[idx];
              slot_id[p] = idx;
            end
          end
          last    = idx;
          any_gnt = 1'b1;
        end
        used = used + 1;
      end
    end

    ptr_nxt = (last == IDW'(REQ - 1)) ? '0 : last + 1'b1;
  end

  // Pointer moves just past the last granted requester; holds when idle.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      ptr <= '0;
    end else if (any_gnt) begin
      ptr <= ptr_nxt;
    end
  end

  // Read return pipeline: tag granted reads and shift them LAT stages.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int unsigned p = 0; p < PORT; p++) begin
        pipe_v[p] <= '0;
        for (int unsigned s = 0; s < LAT; s++) pipe_id[p][s] <= '0;
      end
    end else begin
      for (int unsigned p = 0; p < PORT; p++) begin
        pipe_v[p][0]  <= en[p] && (rw_[p] == `READ);
        pipe_id[p][0] <= slot_id[p];
        for (int unsigned s = 1; s < LAT; s++) begin
          pipe_v[p][s]  <= pipe_v[p][s-1];
          pipe_id[p][s] <= pipe_id[p][s-1];
        end
      end
    end
  end

  // Steer ram read data to the tagged requester. ram_rdata is only valid in
  // the return cycle, so it is passed through then and captured in rdata_q,
  // which supplies the held value on every other cycle.
  always_comb begin
    rvalid = '0;
    rdata  = rdata_q;
    for (int unsigned p = 0; p < PORT; p++) begin
      if (pipe_v[p][LAT-1]) begin
        rvalid[pipe_id[p][LAT-1]] = 1'b1;
        rdata[pipe_id[p][LAT-1]]  = ram_rdata[p];
      end
    end
  end

  // Hold register for returned read data.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      rdata_q <= '0;
    end else begin
      rdata_q <= rdata;
    end
  end

endmodule

// File: tb/tb_ram_arbiter.sv
// tb_ram_arbiter: two arbiters (OUTREG disabled / enabled), each driving a
// small behavioural ram. Grants and port fields are checked inline per test;
// read returns are checked by a scoreboard of expected {requester, data, cycle}.
`timescale 1ns/1ps

`ifndef READ
`define READ 1'b1
`endif
`ifndef WRITE
`define WRITE 1'b0
`endif
`ifndef DISABLE
`define DISABLE 0
`endif
`ifndef ENABLE
`define ENABLE 1
`endif

module tb_ram_arbiter;
  localparam int DATA  = 32;
  localparam int DEPTH = 4;
  localparam int PORT  = 2;
  localparam int REQ   = 4;
  localparam int ADDR  = 2;

  logic clk = 1'b0;
  logic reset = 1'b1;

  logic [REQ-1:0]            req       [2];
  logic [REQ-1:0]            req_rw_   [2];
  logic [REQ-1:0][ADDR-1:0]  req_addr  [2];
  logic [REQ-1:0][DATA-1:0]  req_wdata [2];
  logic [REQ-1:0]            gnt       [2];
  logic [REQ-1:0]            rvalid    [2];
  logic [REQ-1:0][DATA-1:0]  rdata     [2];
  logic [PORT-1:0]           en        [2];
  logic [PORT-1:0]           rw_       [2];
  logic [PORT-1:0][ADDR-1:0] addr      [2];
  logic [PORT-1:0][DATA-1:0] wdata     [2];
  logic [PORT-1:0][DATA-1:0] ram_rdata [2];

  int checks   = 0;
  int failures = 0;
  int cyc      = 0;

  typedef struct {
    int             inst;
    int             id;
    logic [DATA-1:0] data;
    int             due;
  } exp_t;
  exp_t sb[$];

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  ram_arbiter #(.DATA(DATA), .DEPTH(DEPTH), .PORT(PORT), .REQ(REQ), .OUTREG(`DISABLE)) u_dut0 (
    .clk(clk), .reset(reset), .req(req[0]), .req_rw_(req_rw_[0]), .req_addr(req_addr[0]),
    .req_wdata(req_wdata[0]), .gnt(gnt[0]), .rvalid(rvalid[0]), .rdata(rdata[0]), .en(en[0]),
    .rw_(rw_[0]), .addr(addr[0]), .wdata(wdata[0]), .ram_rdata(ram_rdata[0])
  );

  ram_arbiter #(.DATA(DATA), .DEPTH(DEPTH), .PORT(PORT), .REQ(REQ), .OUTREG(`ENABLE)) u_dut1 (
    .clk(clk), .reset(reset), .req(req[1]), .req_rw_(req_rw_[1]), .req_addr(req_addr[1]),
    .req_wdata(req_wdata[1]), .gnt(gnt[1]), .rvalid(rvalid[1]), .rdata(rdata[1]), .en(en[1]),
    .rw_(rw_[1]), .addr(addr[1]), .wdata(wdata[1]), .ram_rdata(ram_rdata[1])
  );

  // behavioural multi-port ram: read registered once (plus once more for instance 1)
  for (genvar g = 0; g < 2; g++) begin : g_ram
    logic [DATA-1:0] mem [DEPTH];
    logic [PORT-1:0][DATA-1:0] st1, st2;
    always @(posedge clk) begin
      for (int p = 0; p < PORT; p++) begin
        if (en[g][p] && rw_[g][p] == `READ) st1[p] <= mem[addr[g][p]];
        st2[p] <= st1[p];
        if (en[g][p] && rw_[g][p] == `WRITE) mem[addr[g][p]] <= wdata[g][p];
      end
    end
    assign ram_rdata[g] = (g == 0) ? st1 : st2;
  end

  // scoreboard: every rvalid must match the oldest expected entry for that requester
  always @(negedge clk) begin
    int hit;
    for (int i = 0; i < 2; i++) begin
      for (int r = 0; r < REQ; r++) begin
        if (rvalid[i][r] === 1'b1) begin
          hit = -1;
          for (int k = 0; k < sb.size(); k++)
            if (hit < 0 && sb[k].inst == i && sb[k].id == r) hit = k;
          checks++;
          if (hit < 0) begin
            failures++;
            $display("FAIL rvalid_unexpected inst=%0d req=%0d cycle=%0d: rvalid=1, required 0", i, r, cyc);
          end else begin
            if (rdata[i][r] !== sb[hit].data || cyc != sb[hit].due) begin
              failures++;
              $display("FAIL read_return inst=%0d req=%0d: got data %h at cycle %0d, required %h at cycle %0d",
                       i, r, rdata[i][r], cyc, sb[hit].data, sb[hit].due);
            end
            sb.delete(hit);
          end
        end
      end
    end
    for (int k = sb.size() - 1; k >= 0; k--) begin
      if (sb[k].due < cyc) begin
        checks++;
        failures++;
        $display("FAIL read_missing inst=%0d req=%0d: no rvalid by cycle %0d, required data %h at cycle %0d",
                 sb[k].inst, sb[k].id, cyc, sb[k].data, sb[k].due);
        sb.delete(k);
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_all();
    for (int i = 0; i < 2; i++) begin
      req[i]       = '0;
      req_rw_[i]   = '1;
      req_addr[i]  = '0;
      req_wdata[i] = '0;
    end
  endtask

  task automatic test_reset();
    clear_all();
    #2 reset = 1'b0;
    @(negedge clk);
    for (int i = 0; i < 2; i++) begin
      checks++; if (gnt[i] !== '0) begin failures++; $display("FAIL reset_gnt inst=%0d got %b required 0000", i, gnt[i]); end
      checks++; if (en[i] !== '0) begin failures++; $display("FAIL reset_en inst=%0d got %b required 00", i, en[i]); end
      checks++; if (rvalid[i] !== '0) begin failures++; $display("FAIL reset_rvalid inst=%0d got %b required 0000", i, rvalid[i]); end
      checks++; if (rdata[i] !== '0) begin failures++; $display("FAIL reset_rdata inst=%0d got %h required 0", i, rdata[i]); end
    end
    for (int i = 0; i < 2; i++) req[i] = '1;
    @(negedge clk);
    for (int i = 0; i < 2; i++) begin
      checks++; if (gnt[i] !== '0) begin failures++; $display("FAIL reset_req_gnt inst=%0d got %b required 0000", i, gnt[i]); end
      checks++; if (en[i] !== '0) begin failures++; $display("FAIL reset_req_en inst=%0d got %b required 00", i, en[i]); end
    end
    @(posedge clk);
    #1;
    clear_all();
    reset = 1'b1;
    for (int c = 0; c < 2; c++) begin
      @(negedge clk);
      checks++; if (gnt[0] !== '0 || en[0] !== '0) begin failures++; $display("FAIL idle_gnt_en got gnt=%b en=%b required 0000/00", gnt[0], en[0]); end
      checks++; if (rvalid[0] !== '0 || rdata[0] !== '0) begin failures++; $display("FAIL idle_rvalid_rdata got %b/%h required 0/0", rvalid[0], rdata[0]); end
    end
    tick();
  endtask

  task automatic test_write_read();
    req_rw_[0][0]   = `WRITE;
    req_addr[0][0]  = 2'd0;
    req_wdata[0][0] = 32'hdaedbeef;
    req[0]          = 4'b0001;
    @(negedge clk);
    checks++; if (gnt[0] !== 4'b0001) begin failures++; $display("FAIL wr_gnt got %b required 0001", gnt[0]); end
    checks++; if (en[0] !== 2'b01 || rw_[0] !== 2'b10) begin failures++; $display("FAIL wr_port got en=%b rw_=%b required 01/10", en[0], rw_[0]); end
    checks++; if (addr[0] !== 4'b0000 || wdata[0] !== {32'h0, 32'hdaedbeef}) begin failures++; $display("FAIL wr_fields got addr=%b wdata=%h", addr[0], wdata[0]); end
    tick();
    req[0] = '0;
    tick();
    req_rw_[0][1]  = `READ;
    req_addr[0][1] = 2'd0;
    req[0]         = 4'b0010;
    @(negedge clk);
    checks++; if (gnt[0] !== 4'b0010) begin failures++; $display("FAIL rd_gnt got %b required 0010", gnt[0]); end
    checks++; if (en[0] !== 2'b01 || rw_[0] !== 2'b11) begin failures++; $display("FAIL rd_port got en=%b rw_=%b required 01/11", en[0], rw_[0]); end
    sb.push_back('{0, 1, 32'hdaedbeef, cyc + 1});
    tick();
    req[0] = '0;
    tick();
    @(negedge clk);
    checks++; if (rvalid[0] !== '0 || rdata[0][1] !== 32'hdaedbeef) begin failures++; $display("FAIL rdata_hold got rvalid=%b rdata=%h required 0000/daedbeef", rvalid[0], rdata[0][1]); end
    tick();
  endtask

  task automatic test_round_robin();
    logic [DATA-1:0] wv [REQ];
    logic [REQ-1:0] pat [3];
    logic [PORT-1:0][ADDR-1:0] apat [3];
    pat[0] = 4'b0011; pat[1] = 4'b1100; pat[2] = 4'b0011;
    apat[0] = 4'b0100; apat[1] = 4'b1110; apat[2] = 4'b0100;
    for (int r = 0; r < REQ; r++) begin
      wv[r]           = 32'hc0de0000 + DATA'(r);
      req_rw_[0][r]   = `WRITE;
      req_addr[0][r]  = ADDR'(r);
      req_wdata[0][r] = wv[r];
    end
    req[0] = 4'b1111;
    @(negedge clk);
    checks++; if (gnt[0] !== 4'b1100) begin failures++; $display("FAIL rr_wr1_gnt got %b required 1100", gnt[0]); end
    checks++; if (addr[0] !== 4'b1110) begin failures++; $display("FAIL rr_wr1_addr got %b required 1110", addr[0]); end
    tick();
    req[0] = 4'b0011;
    @(negedge clk);
    checks++; if (gnt[0] !== 4'b0011) begin failures++; $display("FAIL rr_wr2_gnt got %b required 0011", gnt[0]); end
    tick();
    wv[3]           = 32'hface0003;
    req_wdata[0][3] = wv[3];
    req[0]          = 4'b1000;
    @(negedge clk);
    checks++; if (gnt[0] !== 4'b1000) begin failures++; $display("FAIL rr_wr3_gnt got %b required 1000", gnt[0]); end
    tick();
    req_rw_[0] = '1;
    req[0]     = 4'b1111;
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      checks++; if (gnt[0] !== pat[c]) begin failures++; $display("FAIL rr_rd_gnt cycle %0d got %b required %b", c, gnt[0], pat[c]); end
      checks++; if (en[0] !== 2'b11 || addr[0] !== apat[c]) begin failures++; $display("FAIL rr_rd_port cycle %0d got en=%b addr=%b required 11/%b", c, en[0], addr[0], apat[c]); end
      for (int r = 0; r < REQ; r++)
        if (pat[c][r]) sb.push_back('{0, r, wv[r], cyc + 1});
      tick();
    end
    req[0] = '0;
    tick();
    tick();
  endtask

  task automatic test_outreg();
    req_rw_[1][2]   = `WRITE;
    req_addr[1][2]  = 2'd2;
    req_wdata[1][2] = 32'h12345678;
    req[1]          = 4'b0100;
    @(negedge clk);
    checks++; if (gnt[1] !== 4'b0100) begin failures++; $display("FAIL or_wr_gnt got %b required 0100", gnt[1]); end
    tick();
    req_rw_[1][0]  = `READ;
    req_addr[1][0] = 2'd2;
    req[1]         = 4'b0001;
    @(negedge clk);
    checks++; if (gnt[1] !== 4'b0001) begin failures++; $display("FAIL or_rd1_gnt got %b required 0001", gnt[1]); end
    sb.push_back('{1, 0, 32'h12345678, cyc + 2});
    tick();
    @(negedge clk);
    checks++; if (gnt[1] !== 4'b0001) begin failures++; $display("FAIL or_rd2_gnt got %b required 0001", gnt[1]); end
    checks++; if (rvalid[1] !== '0) begin failures++; $display("FAIL or_early_rvalid got %b required 0000", rvalid[1]); end
    sb.push_back('{1, 0, 32'h12345678, cyc + 2});
    tick();
    req[1] = '0;
    @(negedge clk);
    checks++; if (rvalid[1] !== 4'b0001) begin failures++; $display("FAIL or_rvalid got %b required 0001", rvalid[1]); end
    tick();
    tick();
    tick();
  endtask

  task automatic test_reset_mid_read();
    req_rw_[0][2]  = `READ;
    req_addr[0][2] = 2'd1;
    req[0]         = 4'b0100;
    @(negedge clk);
    checks++; if (gnt[0] !== 4'b0100) begin failures++; $display("FAIL mid_gnt got %b required 0100", gnt[0]); end
    tick();
    req[0] = '0;
    reset  = 1'b0;
    @(negedge clk);
    checks++; if (rvalid[0] !== '0) begin failures++; $display("FAIL mid_reset_rvalid got %b required 0000", rvalid[0]); end
    tick();
    reset = 1'b1;
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      checks++; if (rvalid[0] !== '0) begin failures++; $display("FAIL mid_after_rvalid cycle %0d got %b required 0000", c, rvalid[0]); end
    end
    tick();
    req_rw_[0] = '1;
    for (int r = 0; r < REQ; r++) req_addr[0][r] = ADDR'(r);
    req[0] = 4'b1111;
    @(negedge clk);
    checks++; if (gnt[0] !== 4'b0011) begin failures++; $display("FAIL mid_ptr_restart got %b required 0011", gnt[0]); end
    sb.push_back('{0, 0, 32'hc0de0000, cyc + 1});
    sb.push_back('{0, 1, 32'hc0de0001, cyc + 1});
    tick();
    req[0] = 4'b1100;
    @(negedge clk);
    checks++; if (gnt[0] !== 4'b1100) begin failures++; $display("FAIL mid_second_gnt got %b required 1100", gnt[0]); end
    sb.push_back('{0, 2, 32'hc0de0002, cyc + 1});
    sb.push_back('{0, 3, 32'hface0003, cyc + 1});
    tick();
    req[0] = '0;
    tick();
  endtask

  task automatic test_conflict();
    req_rw_[0][0]   = `WRITE;
    req_rw_[0][1]   = `WRITE;
    req_addr[0][0]  = 2'd3;
    req_addr[0][1]  = 2'd3;
    req_wdata[0][0] = 32'h1;
    req_wdata[0][1] = 32'h2;
    req[0]          = 4'b0011;
`ifdef RAM_ARBITER_WCONFLICT_EN
    @(negedge clk);
    checks++; if (gnt[0] !== 4'b0001) begin failures++; $display("FAIL wc_first_gnt got %b required 0001", gnt[0]); end
    checks++; if (en[0] !== 2'b01) begin failures++; $display("FAIL wc_first_en got %b required 01", en[0]); end
    tick();
    req[0] = 4'b0010;
    @(negedge clk);
    checks++; if (gnt[0] !== 4'b0010) begin failures++; $display("FAIL wc_second_gnt got %b required 0010", gnt[0]); end
    tick();
    req_rw_[0][2]  = `READ;
    req_addr[0][2] = 2'd3;
    req[0]         = 4'b0100;
    @(negedge clk);
    checks++; if (gnt[0] !== 4'b0100) begin failures++; $display("FAIL wc_read_gnt got %b required 0100", gnt[0]); end
    sb.push_back('{0, 2, 32'h2, cyc + 1});
    tick();
    req[0] = '0;
    tick();
`else
    @(negedge clk);
    checks++; if (gnt[0] !== 4'b0011) begin failures++; $display("FAIL wc_both_gnt got %b required 0011", gnt[0]); end
    checks++; if (en[0] !== 2'b11 || rw_[0] !== 2'b00) begin failures++; $display("FAIL wc_both_port got en=%b rw_=%b required 11/00", en[0], rw_[0]); end
    tick();
    req[0] = '0;
    tick();
`endif
    tick();
  endtask

  initial begin
    test_reset();
    test_write_read();
    test_round_robin();
    test_outreg();
    test_reset_mid_read();
    test_conflict();
    for (int c = 0; c < 4; c++) tick();
    checks++;
    if (sb.size() != 0) begin
      failures++;
      $display("FAIL scoreboard_drain got %0d pending reads required 0", sb.size());
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
